// File: rtl/enc_dec_pkg.sv
// -----------------------------------------------------------------------------
// enc_dec_pkg
// Shared types and constants for the encoder/decoder family.
//   dec_state_t : control states of the hold-decoder (IDLE, HOLD, GAP)
//   DEC_CNT_W   : width of the hold/gap down-counter
// -----------------------------------------------------------------------------
package enc_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } dec_state_t;

    localparam int DEC_CNT_W = 8;

endpackage : enc_dec_pkg

// File: rtl/dec_onehot.sv
// -----------------------------------------------------------------------------
// dec_onehot
// Purely combinational N-to-2^N one-hot decoder. Every index is legal:
// index 0 drives bit 0.
// Ports:
//   i_idx    [N_SEL-1:0]  encoded index
//   o_onehot [OUT_W-1:0]  one-hot result, bit i_idx set
// -----------------------------------------------------------------------------
module dec_onehot #(
    parameter  int N_SEL = 3,
    localparam int OUT_W = 2 ** N_SEL
) (
    input  logic [N_SEL-1:0] i_idx,
    output logic [OUT_W-1:0] o_onehot
);

    // NOTE: assign a default before any conditional write in always_comb;
    // a path that leaves a variable unassigned infers a latch.
    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule : dec_onehot

// File: rtl/dec3to8_hold.sv
// -----------------------------------------------------------------------------
// dec3to8_hold
// Sequential one-hot decoder with a guaranteed pulse width. An index accepted
// through a valid/ready handshake drives its one-hot line for HOLD_CYCLES
// cycles, followed by GAP_CYCLES all-zero cycles before the next accept.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_idx is valid this cycle
//   in_idx      [N_SEL-1:0] index to decode
//   in_ready    block can accept this cycle (forced low while rst is high)
//   out_onehot  [OUT_W-1:0] registered one-hot output
//   out_active  registered; high exactly while the one-hot line is driven
//   busy        high in HOLD or GAP
//   done        one-cycle pulse on the last hold cycle
//
// Build option:
//   DEC3TO8_ACTIVE_LOW_EN  when defined, out_onehot is inverted (idle/reset
//                          all ones, selected bit 0) for active-low LEDs or
//                          anodes. Other outputs are unaffected.
// -----------------------------------------------------------------------------
module dec3to8_hold
    import enc_dec_pkg::*;
#(
    parameter  int N_SEL       = 3,
    parameter  int HOLD_CYCLES = 4,   // 1..255
    parameter  int GAP_CYCLES  = 1,   // 0..255
    localparam int OUT_W       = 2 ** N_SEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N_SEL-1:0] in_idx,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_active,
    output logic             busy,
    output logic             done
);

    // XOR mask applied to the decoded value; also the "nothing driven" value.
`ifdef DEC3TO8_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] POL_MASK = '1;
`else
    localparam logic [OUT_W-1:0] POL_MASK = '0;
`endif

    localparam logic [DEC_CNT_W-1:0] HOLD_LOAD = DEC_CNT_W'(HOLD_CYCLES - 1);
    // Never loaded when GAP_CYCLES is 0; kept at 0 so no negative value appears.
    localparam logic [DEC_CNT_W-1:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? DEC_CNT_W'(GAP_CYCLES - 1) : '0;

    dec_state_t             r_state;
    logic [DEC_CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]       r_onehot;
    logic                   r_active;

    dec_state_t             w_state_nxt;
    logic [DEC_CNT_W-1:0]   w_cnt_nxt;
    logic [OUT_W-1:0]       w_onehot_nxt;
    logic                   w_active_nxt;
    logic [OUT_W-1:0]       w_decoded;
    logic                   w_ready;
    logic                   w_accept;

    dec_onehot #(
        .N_SEL    (N_SEL)
    ) u_dec_onehot (
        .i_idx    (in_idx),
        .o_onehot (w_decoded)
    );

    // rst gates ready directly so a request seen together with reset is never
    // acknowledged on the bus.
    assign w_ready  = (r_state == IDLE) & ~rst;
    assign w_accept = in_valid & w_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_onehot_nxt = r_onehot;
        w_active_nxt = r_active;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = HOLD;
                    w_cnt_nxt    = HOLD_LOAD;
                    w_onehot_nxt = w_decoded ^ POL_MASK;
                    w_active_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_onehot_nxt = POL_MASK;
                    w_active_nxt = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_cnt_nxt    = '0;
                w_onehot_nxt = POL_MASK;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_onehot <= POL_MASK;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_onehot <= w_onehot_nxt;
            r_active <= w_active_nxt;
        end
    end

    assign in_ready   = w_ready;
    assign out_onehot = r_onehot;
    assign out_active = r_active;
    assign busy       = (r_state != IDLE);
    // Decoded from registered state, so it falls with the aborted hold on reset.
    assign done       = (r_state == HOLD) && (r_cnt == '0);

endmodule : dec3to8_hold

// File: tb/tb_dec3to8_hold.sv
// -----------------------------------------------------------------------------
// tb_dec3to8_hold
// Two instances share one stimulus stream: A with defaults (hold 4, gap 1) and
// B with hold 1, gap 0. The reference model tracks, per instance, how many
// cycles have elapsed since the last accept and derives every output from
// that distance.
// -----------------------------------------------------------------------------
module tb_dec3to8_hold;

    localparam int HA = 4;
    localparam int GA = 1;
    localparam int HB = 1;
    localparam int GB = 0;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx   = 3'd0;

    logic [7:0] a_onehot, b_onehot;
    logic       a_ready, a_active, a_busy, a_done;
    logic       b_ready, b_active, b_busy, b_done;
    logic [11:0] a_vec, b_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: cycles since the accept edge (1 = first hold cycle), -1 idle.
    int         since_m [2];
    logic [2:0] idx_m   [2];
    int         hc      [2];
    int         gc      [2];

    always #5 clk = ~clk;

    dec3to8_hold #(.N_SEL(3), .HOLD_CYCLES(HA), .GAP_CYCLES(GA)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_idx     (in_idx),
        .in_ready   (a_ready),
        .out_onehot (a_onehot),
        .out_active (a_active),
        .busy       (a_busy),
        .done       (a_done)
    );

    dec3to8_hold #(.N_SEL(3), .HOLD_CYCLES(HB), .GAP_CYCLES(GB)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_idx     (in_idx),
        .in_ready   (b_ready),
        .out_onehot (b_onehot),
        .out_active (b_active),
        .busy       (b_busy),
        .done       (b_done)
    );

    assign a_vec = {a_onehot, a_active, a_busy, a_done, a_ready};
    assign b_vec = {b_onehot, b_active, b_busy, b_done, b_ready};

    // ---------------- reference model ----------------
    function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef DEC3TO8_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    function automatic bit m_busy(input int d);
        return since_m[d] >= 1;
    endfunction

    function automatic bit m_active(input int d);
        return (since_m[d] >= 1) && (since_m[d] <= hc[d]);
    endfunction

    function automatic bit m_done(input int d);
        return since_m[d] == hc[d];
    endfunction

    function automatic bit m_ready(input int d);
        return !m_busy(d) && !rst;
    endfunction

    function automatic logic [7:0] m_onehot(input int d);
        logic [7:0] v;
        v = m_active(d) ? (8'd1 << idx_m[d]) : 8'd0;
        return pol(v);
    endfunction

    function automatic logic [11:0] m_vec(input int d);
        return {m_onehot(d), m_active(d), m_busy(d), m_done(d), m_ready(d)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [2:0] i, input bit r);
        rst      = r;
        in_valid = v;
        in_idx   = i;
        #1;
    endtask

    // Advance one clock edge and move the model with it; returns at negedge.
    task automatic tick();
        bit acc [2];
        for (int d = 0; d < 2; d++) acc[d] = in_valid && m_ready(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                since_m[d] = -1;
            end else if (acc[d]) begin
                since_m[d] = 1;
                idx_m[d]   = in_idx;
            end else if (since_m[d] >= 1) begin
                since_m[d]++;
                if (since_m[d] > hc[d] + gc[d]) since_m[d] = -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic go_idle();
        for (int k = 0; k < 20 && (m_busy(0) || m_busy(1)); k++) begin
            drive(1'b0, 3'($urandom), 1'b0);
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b0, 3'd0, 1'b1);
        n_cmp++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ready_gated: got %b expected 00", {a_ready, b_ready});
        end
        tick();
        drive(1'b0, 3'd0, 1'b1);
        tick();
        drive(1'b0, 3'd0, 1'b0);
        n_cmp++;
        if (a_vec !== m_vec(0)) begin
            n_bad++;
            $display("FAIL reset_state_a: got %h expected %h", a_vec, m_vec(0));
        end
        n_cmp++;
        if (b_vec !== m_vec(1)) begin
            n_bad++;
            $display("FAIL reset_state_b: got %h expected %h", b_vec, m_vec(1));
        end
        n_cmp++;
        if ({a_onehot, a_ready} !== {pol(8'h00), 1'b1}) begin
            n_bad++;
            $display("FAIL reset_value: got %h/%b expected %h/1", a_onehot, a_ready, pol(8'h00));
        end
    endtask

    task automatic test_single_idx5();
        int hold_cnt = 0;
        int done_k   = -1;
        int rdy_k    = -1;
        go_idle();
        drive(1'b1, 3'd5, 1'b0);
        tick();
        for (int k = 1; k <= 7; k++) begin
            drive(1'b0, 3'($urandom), 1'b0);
            n_cmp++;
            if (a_vec !== m_vec(0)) begin
                n_bad++;
                $display("FAIL single_idx5 cyc%0d: got %h expected %h", k, a_vec, m_vec(0));
            end
            if (a_onehot === pol(8'h20)) hold_cnt++;
            if (a_done === 1'b1 && done_k < 0) done_k = k;
            if (a_ready === 1'b1 && rdy_k < 0) rdy_k = k;
            tick();
        end
        n_cmp++;
        if ({hold_cnt, done_k, rdy_k} !== {32'd4, 32'd4, 32'd6}) begin
            n_bad++;
            $display("FAIL single_idx5_timing: got hold=%0d done@%0d ready@%0d expected 4/4/6",
                     hold_cnt, done_k, rdy_k);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] plan [3];
        int         acc_cyc [3];
        logic [7:0] first_val [3];
        int         n = 0;
        bit         just;
        plan = '{3'd0, 3'd7, 3'd3};
        go_idle();
        for (int c = 0; c < 20; c++) begin
            just = 1'b0;
            if (n < 3 && m_ready(0)) begin
                drive(1'b1, plan[n], 1'b0);
                acc_cyc[n] = c;
                n++;
                just = 1'b1;
            end else begin
                drive(1'b1, 3'($urandom), 1'b0);
            end
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if ((d == 0 ? a_vec : b_vec) !== m_vec(d)) begin
                    n_bad++;
                    $display("FAIL back_to_back dut%0d cyc%0d: got %h expected %h",
                             d, c, (d == 0 ? a_vec : b_vec), m_vec(d));
                end
            end
            tick();
            if (just) first_val[n-1] = a_onehot;
        end
        n_cmp++;
        if (n != 3 || acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
            n_bad++;
            $display("FAIL back_to_back_spacing: got accepts=%0d at %0d,%0d,%0d expected spacing 6",
                     n, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        n_cmp++;
        if ({first_val[0], first_val[1], first_val[2]} !==
            {pol(8'h01), pol(8'h80), pol(8'h08)}) begin
            n_bad++;
            $display("FAIL back_to_back_values: got %h %h %h expected %h %h %h",
                     first_val[0], first_val[1], first_val[2],
                     pol(8'h01), pol(8'h80), pol(8'h08));
        end
    endtask

    task automatic test_fast_hold1_gap0();
        bit odd;
        go_idle();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 3'd2, 1'b0);
            odd = (k % 2) == 1;
            n_cmp++;
            if ({b_onehot, b_done, b_ready} !== {pol(odd ? 8'h04 : 8'h00), odd, !odd}) begin
                n_bad++;
                $display("FAIL fast_b cyc%0d: got %h/%b/%b expected %h/%b/%b", k,
                         b_onehot, b_done, b_ready, pol(odd ? 8'h04 : 8'h00), odd, !odd);
            end
            n_cmp++;
            if (b_vec !== m_vec(1)) begin
                n_bad++;
                $display("FAIL fast_b_model cyc%0d: got %h expected %h", k, b_vec, m_vec(1));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_hold();
        go_idle();
        drive(1'b1, 3'd6, 1'b0);
        tick();
        drive(1'b0, 3'd0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 1'b1);
        n_cmp++;
        if ({a_onehot, a_ready, a_busy} !== {pol(8'h40), 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_mid_during: got %h/%b/%b expected %h/0/1",
                     a_onehot, a_ready, a_busy, pol(8'h40));
        end
        tick();
        n_cmp++;
        if ({a_onehot, a_active, a_busy, a_done} !== {pol(8'h00), 3'b000}) begin
            n_bad++;
            $display("FAIL rst_mid_after: got %h/%b/%b/%b expected %h/0/0/0",
                     a_onehot, a_active, a_busy, a_done, pol(8'h00));
        end
        drive(1'b0, 3'd0, 1'b0);
        n_cmp++;
        if (a_vec !== m_vec(0) || a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_ready: got %h expected %h", a_vec, m_vec(0));
        end
    endtask

    task automatic test_rst_with_valid();
        go_idle();
        drive(1'b1, 3'd4, 1'b1);
        n_cmp++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_valid_ready: got %b expected 00", {a_ready, b_ready});
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 3'd0, 1'b0);
            n_cmp++;
            if ({a_onehot, a_active, a_busy, b_onehot, b_active, b_busy} !==
                {pol(8'h00), 2'b00, pol(8'h00), 2'b00}) begin
                n_bad++;
                $display("FAIL rst_valid_no_accept cyc%0d: got a=%h/%b/%b b=%h/%b/%b",
                         k, a_onehot, a_active, a_busy, b_onehot, b_active, b_busy);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), ($urandom_range(0, 39) == 0));
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if ((d == 0 ? a_vec : b_vec) !== m_vec(d)) begin
                    n_bad++;
                    $display("FAIL random dut%0d cyc%0d: got %h expected %h",
                             d, c, (d == 0 ? a_vec : b_vec), m_vec(d));
                end
            end
            n_cmp++;
            if (!$onehot0(pol(a_onehot)) || !$onehot0(pol(b_onehot))) begin
                n_bad++;
                $display("FAIL random_onehot0 cyc%0d: got a=%h b=%h expected at most one bit",
                         c, a_onehot, b_onehot);
            end
            tick();
        end
    endtask

    initial begin
        hc = '{HA, HB};
        gc = '{GA, GB};
        since_m = '{-1, -1};
        idx_m   = '{3'd0, 3'd0};
        test_reset();
        test_single_idx5();
        test_back_to_back();
        test_fast_hold1_gap0();
        test_reset_mid_hold();
        test_rst_with_valid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dec3to8_hold

// File: doc/dec3to8_hold.md
Name: dec3to8_hold

Overview:
- Sequential N-to-2^N one-hot decoder, the counterpart of the team's 8-to-3 priority encoders.
- Accepts an encoded index through a valid/ready handshake and drives the matching one-hot output line for a programmable number of cycles.
- Follows the hold with a programmable all-zero gap, then accepts the next index.
- Typical use on Basys3: decoding encoder output back onto LEDs, anode or row selects, with a guaranteed minimum pulse width.

Parameters:
- N_SEL, 3: index width.
- OUT_W, 2**N_SEL: one-hot output width. Derived; never overridden.
- HOLD_CYCLES, 4: cycles the one-hot output is held. Legal range 1 to 255.
- GAP_CYCLES, 1: all-zero cycles after the hold, before the next accept. Legal range 0 to 255.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_idx is valid this cycle.
- in_idx  input  N_SEL  index to decode.
- in_ready  output  1  block can accept this cycle.
- out_onehot  output  OUT_W  registered one-hot output; bit in_idx is set during the hold.
- out_active  output  1  registered; high exactly while out_onehot is non-zero.
- busy  output  1  high in HOLD or GAP.
- done  output  1  one-cycle pulse on the last hold cycle.

Behaviour:
- Reset: rst is sampled only at the clk edge. After an edge with rst=1:
  - state=IDLE, counter=0;
  - out_onehot=0, out_active=0, busy=0, done=0;
  - in_ready=1 from the first cycle after rst deasserts.
  - in_ready is gated to 0 combinationally while rst=1.
- States: IDLE, HOLD, GAP.
  - in_ready = (state==IDLE) & ~rst.
  - busy = (state!=IDLE).
- IDLE:
  - Accept occurs when in_valid & in_ready.
  - On accept: capture in_idx, load out_onehot = 1<<in_idx, set out_active=1, load counter=HOLD_CYCLES-1, and go to HOLD.
  - Latency: the output is visible the cycle after the accept.
  - in_valid with no accept has no effect. in_idx is ignored outside accept cycles.
- HOLD:
  - Output is held stable.
  - Counter decrements each cycle.
  - When counter==0, assert done for that cycle.
  - Next edge: clear out_onehot and out_active. Then:
    - GAP_CYCLES>0: load counter=GAP_CYCLES-1 and go to GAP;
    - GAP_CYCLES==0: go to IDLE.
- GAP:
  - Output is 0 and in_ready=0.
  - Counter decrements; when counter==0, go to IDLE next edge.
- Throughput:
  - Minimum accept-to-accept spacing is 1+HOLD_CYCLES+GAP_CYCLES cycles.
  - With defaults, accepts can occur every 6 cycles.
- HOLD_CYCLES=1: output is high for exactly one cycle, and done coincides with it.
- Index values: all in_idx values are legal, since OUT_W=2**N_SEL. Index 0 drives bit 0; it does not mean "none". Absence of output is shown only by out_active=0.
- Reset mid-operation: the next edge forces IDLE with all outputs 0. No done pulse is issued for the aborted hold.
- Simultaneous rst and in_valid: rst wins and nothing is accepted.
- Counter width: 8 bits. Decrement never wraps, because the state changes at 0.
- Invariant: out_onehot has at most one bit set in every cycle.

Optional Feature:
- Macro: DEC3TO8_ACTIVE_LOW_EN.
- Defined:
  - out_onehot is inverted for active-low Basys3 anodes/LEDs;
  - reset and idle value is all ones;
  - the selected bit is 0 during the hold.
- Not defined: active-high as described above.
- out_active, done, busy and in_ready are unaffected either way.

Decomposition:
- Shared package enc_dec_pkg holds:
  - state typedef dec_state_t {IDLE=2'd0, HOLD=2'd1, GAP=2'd2};
  - constant DEC_CNT_W=8.
- Sub-module dec_onehot (parameter N_SEL): purely combinational index-to-one-hot decode, instantiated once. The top block owns the registers and the FSM.

Test Plan:
- Reset, then accept in_idx=5 with defaults:
  - out_onehot=8'b0010_0000 for exactly 4 cycles, starting the cycle after the accept;
  - done high on the 4th cycle;
  - 1 gap cycle at 0;
  - in_ready back to 1 on cycle 6.
- Hold in_valid=1 continuously, with in_idx stepping 0,7,3:
  - accepts occur every 6 cycles;
  - outputs are 8'h01, 8'h80, 8'h08;
  - in_idx changes while busy are ignored.
- HOLD_CYCLES=1, GAP_CYCLES=0, in_valid held high with in_idx=2:
  - out_onehot=8'h04 for 1 cycle, alternating with 0;
  - accepts occur every 2 cycles;
  - done pulses each time.
- Assert rst during the 2nd hold cycle of in_idx=6: the next cycle has out_onehot=0, busy=0, and no done; in_ready=1 after rst falls.
- rst and in_valid both high with in_idx=4: no accept; out_onehot stays 0.
- With DEC3TO8_ACTIVE_LOW_EN defined, in_idx=1:
  - reset value 8'hFF;
  - hold value 8'hFD for 4 cycles;
  - value returns to 8'hFF after the hold.
